// File: rtl/chan_mux_pkg.sv
// chan_mux_pkg: shared constants and sizing helper for the channel mux slice.
// Latency: n/a (package only).
// Backpressure: n/a.
// Contents: MODE_FIXED / MODE_RR mode encodings, sel_w() select-width helper.
package chan_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Width of a channel index; never narrower than one bit.
  function automatic int sel_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/chan_mux_rr_if.sv
// chan_mux_rr_if: bundle of the N:1 mux channel-side and sink-side signals.
// Latency: n/a (wires only).
// Backpressure: in_ready toward sources, out_ready from the sink.
// Modports: master = traffic side (drives in_*, mode, sel, out_ready);
//           slave  = mux side (drives in_ready and out_*).
// in_last exists only when CHAN_MUX_LOCK_EN is defined.
interface chan_mux_rr_if import chan_mux_pkg::*; #(
  parameter int NCH = 4,
  parameter int W   = 8
);
  localparam int SEL_W = sel_w(NCH);

  logic [NCH-1:0]   in_valid;
  logic [NCH*W-1:0] in_data;
  logic [NCH-1:0]   in_ready;
`ifdef CHAN_MUX_LOCK_EN
  logic [NCH-1:0]   in_last;
`endif
  logic             mode;
  logic [SEL_W-1:0] sel;
  logic             out_valid;
  logic [W-1:0]     out_data;
  logic [SEL_W-1:0] out_ch;
  logic             out_ready;

  modport master (
    output in_valid, in_data, mode, sel, out_ready,
`ifdef CHAN_MUX_LOCK_EN
    output in_last,
`endif
    input  in_ready, out_valid, out_data, out_ch
  );

  modport slave (
    input  in_valid, in_data, mode, sel, out_ready,
`ifdef CHAN_MUX_LOCK_EN
    input  in_last,
`endif
    output in_ready, out_valid, out_data, out_ch
  );

endinterface

// File: rtl/chan_mux_rr_arbiter.sv
// rr_arbiter: rotating-priority pick of one requester, starting just after ptr.
// Latency: combinational.
// Backpressure: none; the caller decides whether the grant is consumed.
// Ports: req (NCH requests), ptr (last winner), gnt_oh (one-hot), gnt_idx, gnt_vld.
module rr_arbiter import chan_mux_pkg::*; #(
  parameter int NCH = 4
) (
  input  logic [NCH-1:0]          req,
  input  logic [sel_w(NCH)-1:0]   ptr,
  output logic [NCH-1:0]          gnt_oh,
  output logic [sel_w(NCH)-1:0]   gnt_idx,
  output logic                    gnt_vld
);
  localparam int SEL_W = sel_w(NCH);

  int c;

  // Walk from the farthest candidate back to the nearest so the channel
  // closest after ptr is the one left standing.
  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    c       = 0;
    for (int i = NCH; i >= 1; i--) begin
      c = (int'(ptr) + i) % NCH;
      if (req[c]) begin
        gnt_vld = 1'b1;
        gnt_idx = SEL_W'(c);
      end
    end
    if (gnt_vld) gnt_oh[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/chan_mux_rr.sv
// chan_mux_rr: N:1 channel mux, fixed-select or round-robin, one registered output stage.
// Latency: 1 cycle from input accept to out_valid/out_data/out_ch; 1 beat/cycle sustained.
// Backpressure: out_valid && !out_ready holds the register and drops every in_ready.
// Ports: clk, rst_n (async active-low), bus (chan_mux_rr_if.slave).
// Option: CHAN_MUX_LOCK_EN adds in_last and keeps an RR grant on one channel until its last beat.
module chan_mux_rr import chan_mux_pkg::*; #(
  parameter int NCH = 4,
  parameter int W   = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  chan_mux_rr_if.slave  bus
);
  localparam int SEL_W = sel_w(NCH);

  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] grant;
  logic [NCH-1:0]   grant_oh;
  logic             grant_valid;
  logic             load;
  logic             xfer;
  logic             last_beat;

  logic [NCH-1:0]   arb_oh;
  logic [SEL_W-1:0] arb_idx;
  logic             arb_vld;

`ifdef CHAN_MUX_LOCK_EN
  logic             lock;
`endif

  rr_arbiter #(.NCH(NCH)) u_arb (
    .req     (bus.in_valid),
    .ptr     (rr_ptr),
    .gnt_oh  (arb_oh),
    .gnt_idx (arb_idx),
    .gnt_vld (arb_vld)
  );

  // Grant select. An out-of-range sel matches no channel, so nothing is granted.
  // While locked, the held channel is the one in out_ch: only it can have
  // transferred since the lock was taken.
  always_comb begin
    grant       = '0;
    grant_oh    = '0;
    grant_valid = 1'b0;
    if (bus.mode == MODE_FIXED) begin
      for (int k = 0; k < NCH; k++) begin
        if (bus.sel == SEL_W'(k)) begin
          grant       = SEL_W'(k);
          grant_oh[k] = bus.in_valid[k];
          grant_valid = bus.in_valid[k];
        end
      end
    end
`ifdef CHAN_MUX_LOCK_EN
    else if (lock) begin
      for (int k = 0; k < NCH; k++) begin
        if (bus.out_ch == SEL_W'(k)) begin
          grant       = SEL_W'(k);
          grant_oh[k] = bus.in_valid[k];
          grant_valid = bus.in_valid[k];
        end
      end
    end
`endif
    else begin
      grant       = arb_idx;
      grant_oh    = arb_oh;
      grant_valid = arb_vld;
    end
  end

`ifdef CHAN_MUX_LOCK_EN
  assign last_beat = bus.in_last[grant];
`else
  assign last_beat = 1'b1;
`endif

  // Register may load when empty or being drained this cycle.
  assign load         = !bus.out_valid || bus.out_ready;
  assign xfer         = load && grant_valid;
  assign bus.in_ready = xfer ? grant_oh : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_ch    <= '0;
      rr_ptr        <= SEL_W'(NCH - 1);
    end else begin
      if (load) bus.out_valid <= grant_valid;
      if (xfer) begin
        bus.out_data <= bus.in_data[int'(grant)*W +: W];
        bus.out_ch   <= grant;
      end
      // Pointer moves only at packet boundaries (every beat without locking).
      if (xfer && bus.mode == MODE_RR && last_beat) rr_ptr <= grant;
    end
  end

`ifdef CHAN_MUX_LOCK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    lock <= 1'b0;
    else if (bus.mode == MODE_FIXED) lock <= 1'b0;
    else if (xfer)                 lock <= !last_beat;
  end
`endif

endmodule

// File: tb/tb_chan_mux_rr.sv
module tb_chan_mux_rr;
  import chan_mux_pkg::*;

  localparam int NCH = 4;
  localparam int W   = 8;
`ifdef CHAN_MUX_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  chan_mux_rr_if #(.NCH(4), .W(8)) bus ();
  chan_mux_rr_if #(.NCH(6), .W(8)) bus6 ();

  chan_mux_rr #(.NCH(4), .W(8)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
  chan_mux_rr #(.NCH(6), .W(8)) dut6 (.clk(clk), .rst_n(rst_n), .bus(bus6));

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: what the output register holds, the last RR winner and
  // whether a packet currently owns the grant.
  bit         m_valid;
  logic [7:0] m_data;
  int         m_ch;
  int         m_ptr;
  bit         m_lock;

  function automatic void model_grant(output bit gv, output int g);
    gv = 1'b0;
    g  = 0;
    if (bus.mode == MODE_FIXED) begin
      g  = int'(bus.sel);
      gv = bus.in_valid[g];
    end else if (LOCK_EN && m_lock) begin
      g  = m_ch;
      gv = bus.in_valid[g];
    end else begin
      for (int off = 1; off <= NCH; off++) begin
        int c;
        c = (m_ptr + off) % NCH;
        if (!gv && bus.in_valid[c]) begin
          gv = 1'b1;
          g  = c;
        end
      end
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin : model_upd
    bit gv;
    int g;
    bit last;
    if (!rst_n) begin
      m_valid = 1'b0;
      m_data  = 8'h00;
      m_ch    = 0;
      m_ptr   = NCH - 1;
      m_lock  = 1'b0;
    end else begin
      model_grant(gv, g);
      last = 1'b1;
`ifdef CHAN_MUX_LOCK_EN
      last = bus.in_last[g];
`endif
      if (!m_valid || bus.out_ready) begin
        if (gv) begin
          m_data = bus.in_data[g*8 +: 8];
          m_ch   = g;
          if (bus.mode == MODE_RR) begin
            if (last) m_ptr = g;
            m_lock = LOCK_EN && !last;
          end
        end
        m_valid = gv;
      end
      if (bus.mode == MODE_FIXED) m_lock = 1'b0;
    end
  end

  // Every-cycle comparison of the 4-channel DUT against the model.
  always @(negedge clk) begin : compare
    bit gv;
    int g;
    logic [3:0] exp_rdy;
    if (rst_n) begin
      model_grant(gv, g);
      exp_rdy = ((!m_valid || bus.out_ready) && gv) ? 4'(1 << g) : 4'b0;
      chk("in_ready",  32'(bus.in_ready),  32'(exp_rdy));
      chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
      chk("out_data",  32'(bus.out_data),  32'(m_data));
      chk("out_ch",    32'(bus.out_ch),    32'(m_ch));
    end
  end

  int lock_seq [4];

  initial begin
    bus.in_valid  = '0;
    bus.in_data   = '0;
    bus.mode      = MODE_FIXED;
    bus.sel       = '0;
    bus.out_ready = 1'b0;
    bus6.in_valid  = '0;
    bus6.in_data   = '0;
    bus6.mode      = MODE_FIXED;
    bus6.sel       = '0;
    bus6.out_ready = 1'b0;
`ifdef CHAN_MUX_LOCK_EN
    bus.in_last  = '0;
    bus6.in_last = '0;
`endif

    // Reset values before any clock edge.
    #2;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data",  32'(bus.out_data),  32'd0);
    chk("rst_out_ch",    32'(bus.out_ch),    32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Fixed mode, sel=2 carrying A5; 6-channel copy with out-of-range sel=7.
    bus.mode      = MODE_FIXED;
    bus.sel       = 2'd2;
    bus.in_valid  = 4'b0100;
    bus.in_data   = 32'h00A5_0000;
    bus.out_ready = 1'b1;
    bus6.mode      = MODE_FIXED;
    bus6.sel       = 3'd7;
    bus6.in_valid  = 6'b111111;
    bus6.in_data   = 48'h151413121110;
    bus6.out_ready = 1'b1;
    tick();
    @(negedge clk);
    chk("fix_out_valid", 32'(bus.out_valid), 32'd1);
    chk("fix_out_data",  32'(bus.out_data),  32'hA5);
    chk("fix_out_ch",    32'(bus.out_ch),    32'd2);
    chk("fix_in_ready",  32'(bus.in_ready),  32'b0100);
    tick();
    @(negedge clk);
    chk("sel7_in_ready",  32'(bus6.in_ready),  32'd0);
    chk("sel7_out_valid", 32'(bus6.out_valid), 32'd0);
    bus6.sel = 3'd3;
    #1;
    chk("sel3_in_ready", 32'(bus6.in_ready), 32'b001000);
    tick();
    @(negedge clk);
    chk("sel3_out_ch",   32'(bus6.out_ch),   32'd3);
    chk("sel3_out_data", 32'(bus6.out_data), 32'h13);

    // RR from reset, all channels valid: 0,1,2,3,0 with no bubbles.
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    bus.mode      = MODE_RR;
    bus.in_valid  = 4'b1111;
    bus.in_data   = 32'h1312_1110;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      @(negedge clk);
      chk("rr_seq_ch",    32'(bus.out_ch),    32'(i % 4));
      chk("rr_seq_valid", 32'(bus.out_valid), 32'd1);
    end

    // Backpressure for three cycles with ch0's beat held.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      chk("bp_out_ch",   32'(bus.out_ch),   32'd0);
      chk("bp_out_data", 32'(bus.out_data), 32'h10);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_rdy", 32'(bus.in_ready), 32'b0010);
    tick();
    @(negedge clk);
    chk("bp_refill_ch",    32'(bus.out_ch),    32'd1);
    chk("bp_refill_data",  32'(bus.out_data),  32'h11);
    chk("bp_refill_valid", 32'(bus.out_valid), 32'd1);

    // Reset while full: outputs clear without an edge, RR restarts at 0.
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_data",  32'(bus.out_data),  32'd0);
    chk("midrst_ch",    32'(bus.out_ch),    32'd0);
    #2;
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    chk("midrst_restart_ch", 32'(bus.out_ch), 32'd0);

    // ch1 sends a three-beat packet while ch0 and ch2 are also valid (ptr=0).
`ifdef CHAN_MUX_LOCK_EN
    lock_seq = '{1, 1, 1, 2};
    bus.in_last = 4'b0101;
`else
    lock_seq = '{1, 2, 0, 1};
`endif
    bus.in_valid = 4'b0111;
    for (int i = 0; i < 4; i++) begin
      tick();
      @(negedge clk);
      chk("pkt_seq_ch", 32'(bus.out_ch), 32'(lock_seq[i]));
`ifdef CHAN_MUX_LOCK_EN
      if (i == 1) bus.in_last = 4'b0111;
`endif
    end

    // Randomized traffic against the model.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      bus.in_valid  = 4'($urandom);
      bus.in_data   = 32'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.sel       = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) bus.mode = ~bus.mode;
`ifdef CHAN_MUX_LOCK_EN
      bus.in_last = 4'($urandom);
`endif
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
      end
    end

    tick();
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
